axis_packer: RTL

- Packs a narrow AXI-Stream word stream into a wide one; the inverse of the wide-to-narrow unpacker.
- Beat 0 of each group goes into the least-significant slice, so the output feeds straight back into the unpacker with byte order preserved.
- Sits between byte-wide sources (UART/PHY/parser logic) and wide datapaths (FIFOs, DMA, MAC).
- Handles early packet termination on input tlast by emitting a zero-padded partial word.

---
 rtl/axis_packer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/axis_packer.sv
`default_nettype none
// ============================================================================
// Module   : axis_packer
// Purpose  : Packs a narrow AXI-Stream into a wide one; beat 0 of each group
//            lands in the least-significant slice, short packets zero-padded.
//            Optional byte enables on axis_o_tkeep via AXIS_PACKER_TKEEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axis_packer #(
    parameter int AXIS_I_BYTES = 1,
    parameter int AXIS_O_BYTES = 8
) (
    input  logic                      clk,
    input  logic                      sresetn,
    output logic                      axis_i_tready,
    input  logic                      axis_i_tvalid,
    input  logic                      axis_i_tlast,
    input  logic [AXIS_I_BYTES*8-1:0] axis_i_tdata,
    input  logic                      axis_o_tready,
    output logic                      axis_o_tvalid,
    output logic                      axis_o_tlast,
    output logic [AXIS_O_BYTES*8-1:0] axis_o_tdata
`ifdef AXIS_PACKER_TKEEP_EN
    ,
    output logic [AXIS_O_BYTES-1:0]   axis_o_tkeep
`endif
);

    localparam int CTR_MAX   = AXIS_O_BYTES / AXIS_I_BYTES;
    localparam int CTR_HIGH  = CTR_MAX - 1;
    localparam int CTR_WIDTH = (CTR_MAX == 1) ? 1 : $clog2(CTR_MAX);
    localparam int IW        = AXIS_I_BYTES * 8;
    localparam int OW        = AXIS_O_BYTES * 8;

    localparam logic [CTR_WIDTH-1:0] c_ctr_high = CTR_WIDTH'(CTR_HIGH);
    localparam logic [CTR_WIDTH-1:0] c_ctr_one  = CTR_WIDTH'(1);

    logic [CTR_WIDTH-1:0] r_ctr;
    logic [OW-1:0]        r_acc;
    logic                 r_o_valid;
    logic                 r_o_last;
    logic [OW-1:0]        r_o_data;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_final;
    logic                 w_load;
    logic [OW-1:0]        w_merged;

    // Ready depends only on output-register state, never on tvalid/tlast.
    assign w_ready  = sresetn && (!r_o_valid || axis_o_tready);
    assign w_accept = axis_i_tvalid && w_ready;
    assign w_final  = (r_ctr == c_ctr_high) || axis_i_tlast;
    assign w_load   = w_accept && w_final;

    // Slices above ctr are still zero in the accumulator, so the merge pads.
    always_comb begin
        w_merged = r_acc;
        for (int s = 0; s < CTR_MAX; s++) begin
            if (r_ctr == CTR_WIDTH'(s)) begin
                w_merged[s*IW +: IW] = axis_i_tdata;
            end
        end
    end

`ifdef AXIS_PACKER_TKEEP_EN
    logic [AXIS_O_BYTES-1:0] r_o_keep;
    logic [AXIS_O_BYTES-1:0] w_keep;

    always_comb begin
        w_keep = '0;
        for (int s = 0; s < CTR_MAX; s++) begin
            if (CTR_WIDTH'(s) <= r_ctr) begin
                w_keep[s*AXIS_I_BYTES +: AXIS_I_BYTES] = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_o_keep <= '0;
        end else if (w_load) begin
            r_o_keep <= w_keep;
        end
    end

    assign axis_o_tkeep = r_o_keep;
`endif

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_ctr     <= '0;
            r_acc     <= '0;
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
            r_o_data  <= '0;
        end else begin
            if (r_o_valid && axis_o_tready) begin
                r_o_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_final) begin
                    r_o_data  <= w_merged;
                    r_o_last  <= axis_i_tlast;
                    r_o_valid <= 1'b1;
                    r_acc     <= '0;
                    r_ctr     <= '0;
                end else begin
                    r_acc <= w_merged;
                    r_ctr <= r_ctr + c_ctr_one;
                end
            end
        end
    end

    assign axis_i_tready = w_ready;
    assign axis_o_tvalid = r_o_valid;
    assign axis_o_tlast  = r_o_last;
    assign axis_o_tdata  = r_o_data;

endmodule
`default_nettype wire
